serial_seq_detector: RTL
========================

# serial_seq_detector

Serial bit-stream pattern detector that consumes the registered data bit `q` produced by the synchronous D flip-flop stage, one bit per qualified clock. It shifts received bits into a window, flags each occurrence of a fixed pattern with a one-cycle pulse, and keeps a saturating match count. It is the first consumer stage downstream of the flop in the sequential-circuit chain.

## Interface
- `PATTERN_W`, 4: pattern length in bits, legal range 2..16.
- `PATTERN`, 4'b1011: target pattern. The MSB is the first bit received.
- `CNT_W`, 8: width of the match counter.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `clear`  input  1  synchronous soft clear of window, fill, pulse and counter.
- `din`  input  1  serial data bit (the flop's `q`).
- `din_valid`  input  1  `din` is sampled only when this is 1.
- `overlap`  input  1  1 = overlapping detection, 0 = non-overlapping.
- `match`  output  1  one-cycle pulse per detected pattern.
- `match_count`  output  CNT_W  number of matches, saturating.
- `armed`  output  1  window holds PATTERN_W valid bits.

## Operation
- Window `shreg[PATTERN_W-1:0]`. On a valid sample it is updated as `{shreg[PATTERN_W-2:0], din}`.
- Fill counter `fill`, 0..PATTERN_W: increments on each valid sample and saturates at PATTERN_W.
- FSM, three states:
  - EMPTY (fill=0) -> FILLING on the first valid sample.
  - FILLING -> ARMED when fill reaches PATTERN_W.
  - ARMED: every valid sample is compared.
- Detection: the next window equals PATTERN and the next fill equals PATTERN_W. When this holds, `match` is 1 on the following cycle.
- After a match:
  - Overlap=1: stay ARMED and keep the window, so trailing bits can begin the next match.
  - Overlap=0: fill <- 0, state <- EMPTY, window <- 0. The next match needs PATTERN_W fresh bits.
- `overlap` is sampled per valid bit. Changing it mid-stream takes effect at the next match.
- `match_count` increments by 1 on each match and holds at 2^CNT_W-1.
- `armed` = (state == ARMED).
- Priority: `rst` low > `clear` high > `din_valid`.

## Timing
- Reset, with `rst` low at a rising edge: shreg=0, fill=0, state=EMPTY, match=0, match_count=0, armed=0.
- Reset mid-pattern discards all partial bits. No match is emitted for bits sampled in that cycle.
- `clear` has the same effect as reset on all state and outputs, one cycle.
- `din_valid`=0: window, fill, state and count hold; `match` is 0.
- Latency: the completing bit is sampled at edge N, `match` is high for cycle N..N+1 and is 0 afterwards unless another match occurs.
- `match_count` updates at the same edge that raises `match`.
- Back-to-back matches (overlap=1, e.g. PATTERN=1111 fed 1s) give `match` high on consecutive cycles.
- Counter saturation: at max, a further match still pulses `match` but the count stays at max.
- `armed` rises at the edge where fill reaches PATTERN_W. With overlap=0 it drops at the edge after a match.

## Structure
- Shared package `seq_pkg`: state enum {EMPTY, FILLING, ARMED} and default PATTERN/PATTERN_W constants.
- One sub-module is natural: `sat_counter` (CNT_W, inc, clr, sync active-low rst), reusable elsewhere in the chain.
- Window, fill and FSM live in the top module.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `din`=1 and `din_valid`=1 -> match=0, match_count=0, armed=0 throughout.
- Overlap=1, stream 1,0,1,1,0,1,1 (all valid) -> match pulses after bit 4 and after bit 7; match_count=2.
- Overlap=0, same stream -> a single pulse after bit 4; match_count=1; armed=0 after the pulse and again before bit 7.
- Gaps: 1,0,1,1 with `din_valid`=0 for 3 cycles between bits 2 and 3 -> exactly one pulse, the cycle after bit 4 is sampled.
- Mid-pattern reset/clear: 1,0,1, then `clear`=1, then 1 -> no match; fill=1 after the final bit.
- Saturation with CNT_W=2 and overlap=1: stream 1,0,1,1 repeated 5 times -> 5 pulses; match_count stops at 3.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial sequence detector.
package seq_pkg;
   typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;

   localparam int          DEF_PATTERN_W = 4;
   localparam logic [3:0]  DEF_PATTERN   = 4'b1011;
   localparam int          DEF_CNT_W     = 8;
endpackage

// File: rtl/serial_seq_detector_if.sv
// Stream/result bundle between the bit source and the sequence detector.
interface serial_seq_detector_if #(parameter int CNT_W = 8);
   logic             clear;
   logic             din;
   logic             din_valid;
   logic             overlap;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             armed;

   modport master (output clear, din, din_valid, overlap,
                   input  match, match_count, armed);
   modport slave  (input  clear, din, din_valid, overlap,
                   output match, match_count, armed);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and sync active-low reset.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end
endmodule

// File: rtl/serial_seq_detector.sv
// Serial pattern detector: shift window, fill tracking, match pulse and
// saturating match count.
module serial_seq_detector
   import seq_pkg::*;
#(
   parameter int                   PATTERN_W = DEF_PATTERN_W,
   parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
   parameter int                   CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_seq_detector_if.slave bus
);
   localparam int              FW   = $clog2(PATTERN_W + 1);
   localparam logic [FW-1:0]   FULL = FW'(PATTERN_W);

   logic [PATTERN_W-1:0] shreg, shreg_n;
   logic [FW-1:0]        fill, fill_n;
   state_t               state, state_n;
   logic                 match_q;
   logic                 ovl_q;
   logic                 flush;
   logic                 detect;
   logic                 armed;
   logic [CNT_W-1:0]     cnt_q;

   // A non-overlapping match is flushed on the cycle the pulse is visible;
   // a bit sampled in that same cycle becomes the first fresh bit.
   always_comb begin
      flush   = match_q && !ovl_q;
      shreg_n = shreg;
      fill_n  = fill;
      if (flush) begin
         shreg_n = '0;
         fill_n  = '0;
         if (bus.din_valid) begin
            shreg_n = {{(PATTERN_W-1){1'b0}}, bus.din};
            fill_n  = FW'(1);
         end
      end else if (bus.din_valid) begin
         shreg_n = {shreg[PATTERN_W-2:0], bus.din};
         fill_n  = (fill == FULL) ? fill : fill + FW'(1);
      end
      detect = bus.din_valid && !flush && (shreg_n == PATTERN) && (fill_n == FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= EMPTY;
      else if (bus.clear)
         state <= EMPTY;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         EMPTY:
            if (bus.din_valid)
               state_n = (fill_n == FULL) ? ARMED : FILLING;
         FILLING:
            if (bus.din_valid && (fill_n == FULL))
               state_n = ARMED;
         ARMED:
            if (flush)
               state_n = bus.din_valid ? FILLING : EMPTY;
         default:
            state_n = EMPTY;
      endcase
   end

   always_comb begin
      armed = (state == ARMED);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg   <= '0;
         fill    <= '0;
         match_q <= 1'b0;
         ovl_q   <= 1'b0;
      end else if (bus.clear) begin
         shreg   <= '0;
         fill    <= '0;
         match_q <= 1'b0;
         ovl_q   <= 1'b0;
      end else begin
         shreg   <= shreg_n;
         fill    <= fill_n;
         match_q <= detect;
         if (bus.din_valid)
            ovl_q <= bus.overlap;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.clear),
      .inc (detect),
      .cnt (cnt_q)
   );

   assign bus.match       = match_q;
   assign bus.match_count = cnt_q;
   assign bus.armed       = armed;
endmodule
